sysid_probe_master: RTL and testbench
=====================================

// Module: sysid_probe_master
// PURPOSE
//  Avalon-MM read master that interrogates the system ID slave (addr 0 = system ID, addr 1 = build timestamp).
//  On start (or automatically out of reset) it reads both words and compares them against expected constants.
//  It then reports pass/fail. Sits beside the CPU and gates boot/LED status on a matching hardware image.
// PARAMETERS
//  EXPECTED_ID        32'd0           expected word at address 0
//  EXPECTED_TIMESTAMP 32'd1519153727  expected word at address 1
//  READ_LATENCY       0               fixed slave read latency in cycles after acceptance (0..3)
//  TIMEOUT_CYCLES     255             max waitrequest-stalled cycles per read before abort (1..65535)
//  AUTO_START         1               1: run once automatically after reset release
// PORTS
//  clock              in   1   system clock
//  reset_n            in   1   synchronous active-low reset
//  start              in   1   1-cycle pulse; begins probe, ignored unless in IDLE or DONE
//  avm_address        out  1   slave word address (0 = ID, 1 = timestamp)
//  avm_read           out  1   read request
//  avm_waitrequest    in   1   slave stall; request held while high
//  avm_readdata       in   32  read data
//  busy               out  1   high from probe start until DONE
//  done               out  1   high in DONE state (sticky until next start)
//  pass               out  1   done & id_match & ts_match & !timeout
//  id_match           out  1   captured ID == EXPECTED_ID
//  ts_match           out  1   captured timestamp == EXPECTED_TIMESTAMP
//  timeout            out  1   a read exceeded TIMEOUT_CYCLES
//  id_value           out  32  captured ID word
//  ts_value           out  32  captured timestamp word
// BEHAVIOUR
//  - Reset (sync, reset_n==0 at posedge): all outputs 0, state IDLE, counters 0; a probe in flight is abandoned, avm_read drops the next cycle.
//  - States: IDLE -> REQ_ID -> LAT_ID -> REQ_TS -> LAT_TS -> DONE; DONE -> REQ_ID on start.
//  - AUTO_START=1: IDLE -> REQ_ID on the first cycle after reset release; otherwise only on start.
//  - REQ_x: avm_read=1, avm_address fixed; held stable while avm_waitrequest=1.
//  - A read is accepted at the edge where avm_read & !avm_waitrequest.
//  - READ_LATENCY=0: readdata is captured at the accept edge, skipping LAT_x; total probe is 2 cycles without stalls.
//  - READ_LATENCY=N>0: avm_read deasserts after accept; LAT_x counts N cycles, then captures readdata.
//  - Timeout counter: cleared on entering REQ_x, increments each stalled cycle.
//  - Timeout: on reaching TIMEOUT_CYCLES, timeout<=1, avm_read<=0, go DONE; uncaptured values stay 0, matches 0.
//  - id_match/ts_match/pass update only on entering DONE.
//  - start during DONE clears done/pass/matches/timeout/values in the same cycle busy rises.
//  - start while busy: ignored. start and reset together: reset wins.
// CONFIGURATION
//  SYSID_PROBE_RETRY_EN defined: a mismatch or timeout restarts at REQ_ID, up to 3 retries.
//    retry_count out 2 bits reports retries used; done rises only after success or the final attempt.
//  Undefined: single attempt; retry_count port absent; DONE entered directly on first result.
// STRUCTURE
//  Package sysid_probe_pkg: state enum (IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, DONE), SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1,
//    and MAX_RETRIES=3.
//  Sub-module sysid_probe_timer: loadable down-counter shared by timeout and latency counting.
//    Ports: clear, enable, expire.
// TESTING
//  1. Zero-latency slave, no stall, ID=0, TS=1519153727 -> done @ cycle 3 after reset, pass=1, id_value=0.
//  2. waitrequest high 10 cycles on ID read -> address/read held stable; pass=1; busy for 12 cycles.
//  3. Slave returns TS=32'h12345678 -> done=1, ts_match=0, pass=0, ts_value=32'h12345678.
//  4. waitrequest stuck high, TIMEOUT_CYCLES=255 -> timeout=1 after 255 stall cycles, avm_read=0, pass=0.
//  5. reset_n low mid-LAT_TS (READ_LATENCY=2) -> next cycle all outputs 0; AUTO_START reprobes cleanly.
//  6. RETRY_EN: first TS read wrong, second correct -> retry_count=1, pass=1; start while busy ignored.

Source files
------------

// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system ID probe master.
package sysid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_ID = 3'd1,
        LAT_ID = 3'd2,
        REQ_TS = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } probe_state_e;

    localparam logic        SYSID_ADDR_ID = 1'b0;
    localparam logic        SYSID_ADDR_TS = 1'b1;
    localparam int unsigned MAX_RETRIES   = 3;

endpackage

// File: rtl/sysid_probe_timer.sv
// Loadable down-counter; expire flags the enabled cycle in which the count reaches its last tick.
module sysid_probe_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = enable && (count == W'(1));

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM read master that fetches the system ID and build timestamp and reports a match.
// Optional feature: define SYSID_PROBE_RETRY_EN to retry a failed probe up to MAX_RETRIES times.
module sysid_probe_master
    import sysid_probe_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1519153727,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    output logic         avm_address,
    output logic         avm_read,
    input  logic         avm_waitrequest,
    input  logic [31:0]  avm_readdata,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         id_match,
    output logic         ts_match,
    output logic         timeout,
    output logic [31:0]  id_value,
    output logic [31:0]  ts_value,
`ifdef SYSID_PROBE_RETRY_EN
    output logic [1:0]   retry_count,
`endif
    output probe_state_e state_dbg
);

    // Avalon handshake: a read is accepted at the rising edge where avm_read=1 and
    // avm_waitrequest=0; while waitrequest is high, address and read stay unchanged.

    probe_state_e state, state_next;
    logic         auto_fired;
    logic         begin_probe, restart, finish, fail_timeout;
    logic         capture_id, capture_ts;
    logic         ok_id, ok_ts;
    logic         timer_load, timer_enable, timer_expire;
    logic [15:0]  timer_value;

    assign avm_read    = (state == REQ_ID) || (state == REQ_TS);
    assign avm_address = (state == REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);
    assign pass        = done && id_match && ts_match && !timeout;
    assign state_dbg   = state;

    always_comb begin
        state_next   = state;
        begin_probe  = 1'b0;
        restart      = 1'b0;
        finish       = 1'b0;
        fail_timeout = 1'b0;
        capture_id   = 1'b0;
        capture_ts   = 1'b0;
        case (state)
            IDLE: begin
                if (start || (AUTO_START && !auto_fired)) begin
                    begin_probe = 1'b1;
                    state_next  = REQ_ID;
                end
            end
            REQ_ID: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        capture_id = 1'b1;
                        state_next = REQ_TS;
                    end else begin
                        state_next = LAT_ID;
                    end
                end else if (timer_expire) begin
                    fail_timeout = 1'b1;
                    finish       = 1'b1;
                end
            end
            LAT_ID: begin
                if (timer_expire) begin
                    capture_id = 1'b1;
                    state_next = REQ_TS;
                end
            end
            REQ_TS: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        capture_ts = 1'b1;
                        finish     = 1'b1;
                    end else begin
                        state_next = LAT_TS;
                    end
                end else if (timer_expire) begin
                    fail_timeout = 1'b1;
                    finish       = 1'b1;
                end
            end
            LAT_TS: begin
                if (timer_expire) begin
                    capture_ts = 1'b1;
                    finish     = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    begin_probe = 1'b1;
                    state_next  = REQ_ID;
                end
            end
            default: state_next = IDLE;
        endcase

        // ID is already registered by the time the timestamp completes a probe.
        ok_id = !fail_timeout && (id_value == EXPECTED_ID);
        ok_ts = !fail_timeout && capture_ts && (avm_readdata == EXPECTED_TIMESTAMP);

        if (finish) begin
`ifdef SYSID_PROBE_RETRY_EN
            if (!(ok_id && ok_ts) && (retry_count != 2'(MAX_RETRIES))) begin
                restart    = 1'b1;
                state_next = REQ_ID;
            end else begin
                state_next = DONE;
            end
`else
            state_next = DONE;
`endif
        end

        // One timer serves both the stall timeout (REQ_x) and the latency wait (LAT_x).
        timer_enable = (avm_read && avm_waitrequest) || (state == LAT_ID) || (state == LAT_TS);
        timer_load   = restart || ((state_next != state) && (state_next != IDLE) && (state_next != DONE));
        timer_value  = ((state_next == LAT_ID) || (state_next == LAT_TS)) ?
                       16'(READ_LATENCY) : 16'(TIMEOUT_CYCLES);
    end

    sysid_probe_timer #(.W(16)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (timer_load),
        .enable     (timer_enable),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            auto_fired <= 1'b0;
            id_value   <= '0;
            ts_value   <= '0;
            id_match   <= 1'b0;
            ts_match   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state <= state_next;
            if (begin_probe) begin
                auto_fired <= 1'b1;
            end
            if (begin_probe || restart) begin
                id_value <= '0;
                ts_value <= '0;
                id_match <= 1'b0;
                ts_match <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                if (capture_id) begin
                    id_value <= avm_readdata;
                end
                if (capture_ts) begin
                    ts_value <= avm_readdata;
                end
                if (finish) begin
                    timeout  <= fail_timeout;
                    id_match <= ok_id;
                    ts_match <= ok_ts;
                end
            end
        end
    end

`ifdef SYSID_PROBE_RETRY_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retry_count <= '0;
        end else if (begin_probe) begin
            retry_count <= '0;
        end else if (restart) begin
            retry_count <= retry_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sysid_probe_master.sv
// Directed bench for sysid_probe_master: a zero-latency instance and a latency-2 instance.
module tb_sysid_probe_master;
    import sysid_probe_pkg::*;

    localparam logic [31:0] GOOD_TS = 32'd1519153727;
    localparam logic [31:0] BAD_TS  = 32'h12345678;
    localparam logic [31:0] ID1     = 32'hCAFE0001;

    logic clock;
    int   tests = 0;
    int   fails = 0;

    // zero-latency instance
    logic         rst0_n, start0, addr0, read0, wait0;
    logic [31:0]  rdata0, id_value0, ts_value0;
    logic         busy0, done0, pass0, idm0, tsm0, tmo0;
    probe_state_e state0;
`ifdef SYSID_PROBE_RETRY_EN
    logic [1:0]   retry0;
`endif

    // latency-2 instance
    logic         rst1_n, start1, addr1, read1, wait1;
    logic [31:0]  rdata1, id_value1, ts_value1;
    logic         busy1, done1, pass1, idm1, tsm1, tmo1;
    probe_state_e state1;
`ifdef SYSID_PROBE_RETRY_EN
    logic [1:0]   retry1;
`endif

    logic [31:0]  id_word, ts_word;
    logic [1:0]   lat_vld, lat_addr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rdata0 = addr0 ? ts_word : id_word;

    always @(posedge clock) begin
        lat_vld  <= {lat_vld[0], read1 & ~wait1};
        lat_addr <= {lat_addr[0], addr1};
    end
    assign rdata1 = lat_vld[1] ? (lat_addr[1] ? ts_word : ID1) : 32'hDEADBEEF;

    sysid_probe_master dut0 (
        .clock(clock), .reset_n(rst0_n), .start(start0),
        .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0), .avm_readdata(rdata0),
        .busy(busy0), .done(done0), .pass(pass0), .id_match(idm0), .ts_match(tsm0),
        .timeout(tmo0), .id_value(id_value0), .ts_value(ts_value0),
`ifdef SYSID_PROBE_RETRY_EN
        .retry_count(retry0),
`endif
        .state_dbg(state0)
    );

    sysid_probe_master #(
        .EXPECTED_ID(ID1), .READ_LATENCY(2), .TIMEOUT_CYCLES(15)
    ) dut1 (
        .clock(clock), .reset_n(rst1_n), .start(start1),
        .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wait1), .avm_readdata(rdata1),
        .busy(busy1), .done(done1), .pass(pass1), .id_match(idm1), .ts_match(tsm1),
        .timeout(tmo1), .id_value(id_value1), .ts_value(ts_value1),
`ifdef SYSID_PROBE_RETRY_EN
        .retry_count(retry1),
`endif
        .state_dbg(state1)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cnt;
        rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        wait0 = 1'b0; wait1 = 1'b0; id_word = 32'd0; ts_word = GOOD_TS;
        lat_vld = '0; lat_addr = '0;
        repeat (3) step();

        // reset state
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_read", 32'(read0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_state", 32'(state0), 32'(IDLE));

        // 1: auto start, zero latency, no stall -> done on third edge
        rst0_n = 1'b1;
        step();
        check("t1_busy", 32'(busy0), 32'd1);
        check("t1_read_id", {30'd0, read0, addr0}, 32'h2);
        step();
        check("t1_read_ts", {30'd0, read0, addr0}, 32'h3);
        check("t1_done_early", 32'(done0), 32'd0);
        step();
        check("t1_done", 32'(done0), 32'd1);
        check("t1_pass", 32'(pass0), 32'd1);
        check("t1_busy_off", 32'(busy0), 32'd0);
        check("t1_read_off", 32'(read0), 32'd0);
        check("t1_id_value", id_value0, 32'd0);
        check("t1_ts_value", ts_value0, GOOD_TS);

        // 2: 10 stall cycles on ID read, start while busy is ignored
        wait0 = 1'b1; start0 = 1'b1;
        step();
        start0 = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) wait0 = 1'b0;
            start0 = (i == 5);
            if (busy0) busy_cnt++;
            if (i < 10) check("t2_hold", {30'd0, read0, addr0}, 32'h2);
            step();
        end
        start0 = 1'b0;
        check("t2_busy_cycles", 32'(busy_cnt), 32'd12);
        check("t2_done", 32'(done0), 32'd1);
        check("t2_pass", 32'(pass0), 32'd1);

`ifndef SYSID_PROBE_RETRY_EN
        // 3: wrong timestamp
        ts_word = BAD_TS; start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("t3_cleared_done", 32'(done0), 32'd0);
        check("t3_cleared_ts", ts_value0, 32'd0);
        check("t3_busy", 32'(busy0), 32'd1);
        step(); step();
        check("t3_done", 32'(done0), 32'd1);
        check("t3_id_match", 32'(idm0), 32'd1);
        check("t3_ts_match", 32'(tsm0), 32'd0);
        check("t3_pass", 32'(pass0), 32'd0);
        check("t3_ts_value", ts_value0, BAD_TS);

        // 4: waitrequest stuck high -> timeout after 255 stalled cycles
        ts_word = GOOD_TS; wait0 = 1'b1; start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (254) step();
        check("t4_still_busy", 32'(busy0), 32'd1);
        check("t4_no_timeout_yet", 32'(tmo0), 32'd0);
        step();
        check("t4_timeout", 32'(tmo0), 32'd1);
        check("t4_done", 32'(done0), 32'd1);
        check("t4_read_off", 32'(read0), 32'd0);
        check("t4_pass", 32'(pass0), 32'd0);
        check("t4_id_match", 32'(idm0), 32'd0);
        wait0 = 1'b0;
`else
        // 6: first timestamp wrong, retry succeeds
        ts_word = BAD_TS; start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        check("t6_state_ts", 32'(state0), 32'(REQ_TS));
        start0 = 1'b1;
        step();
        start0 = 1'b0; ts_word = GOOD_TS;
        check("t6_restart", 32'(state0), 32'(REQ_ID));
        check("t6_retry1", 32'(retry0), 32'd1);
        step(); step();
        check("t6_done", 32'(done0), 32'd1);
        check("t6_pass", 32'(pass0), 32'd1);
        check("t6_retry_final", 32'(retry0), 32'd1);
`endif

        // 5: latency-2 instance, reset during LAT_TS, then clean reprobe
        rst1_n = 1'b1;
        step();
        check("t5_req_id", {30'd0, read1, addr1}, 32'h2);
        step();
        check("t5_lat_read_off", 32'(read1), 32'd0);
        check("t5_lat_id", 32'(state1), 32'(LAT_ID));
        step(); step();
        check("t5_id_value", id_value1, ID1);
        check("t5_req_ts", {30'd0, read1, addr1}, 32'h3);
        step();
        check("t5_lat_ts", 32'(state1), 32'(LAT_TS));
        rst1_n = 1'b0;
        step();
        check("t5_rst_outputs", {25'd0, busy1, done1, pass1, idm1, tsm1, tmo1, read1}, 32'd0);
        check("t5_rst_addr", 32'(addr1), 32'd0);
        check("t5_rst_id_value", id_value1, 32'd0);
        check("t5_rst_state", 32'(state1), 32'(IDLE));
        rst1_n = 1'b1;
        repeat (6) step();
        check("t5_not_done_yet", 32'(done1), 32'd0);
        step();
        check("t5_done", 32'(done1), 32'd1);
        check("t5_pass", 32'(pass1), 32'd1);
        check("t5_ts_value", ts_value1, GOOD_TS);
        check("t5_id_value2", id_value1, ID1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
